// File: rtl/mem_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_initiator
//  Purpose  : Single-outstanding bus master. Accepts commands on a valid/ready
//             port, runs one mem_read/mem_write handshake with timeout
//             protection, and returns data or an error on a response port.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_initiator #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   // command port
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // memory bus
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   // response port
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic [7:0]        err_count
);

   // Timer only has to count 0 .. TIMEOUT-1 cycles spent waiting in REQ.
   localparam int                 c_TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_TIMER_W-1:0]   r_timer;
   logic                   w_misaligned;
   logic                   w_timer_done;

   assign cmd_ready    = (r_state == ST_IDLE);
   assign w_misaligned = (cmd_addr[1:0] != 2'b00);
   assign w_timer_done = (r_timer == c_TIMER_LAST);

   // Sequencer: command capture, bus request with timeout, response hold.
   // The bus address/data registers double as the command latches, and are
   // cleared whenever the request ends so they read as 0 outside REQ.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
         err_count  <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (w_misaligned) begin
                     // Rejected without touching the bus.
                     r_state    <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     resp_error <= 1'b1;
                     if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                     end
                  end else begin
                     r_state   <= ST_REQ;
                     r_timer   <= '0;
                     mem_read  <= ~cmd_write;
                     mem_write <= cmd_write;
                     mem_addr  <= cmd_addr;
                     mem_wdata <= cmd_write ? cmd_wdata : '0;
                  end
               end
            end

            ST_REQ: begin
               if (mem_ready) begin
                  // Completion takes priority over a coincident timeout.
                  r_state    <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= mem_write ? '0 : mem_rdata;
                  resp_error <= 1'b0;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
               end else if (w_timer_done) begin
                  r_state    <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= '0;
                  resp_error <= 1'b1;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            ST_RESP: begin
               if (resp_ready) begin
                  r_state    <= ST_IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_error <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_initiator
//  Purpose  : Self-checking bench for mem_bus_initiator with a bus responder
//             and a command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_initiator;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        mem_read, mem_write, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic [7:0]  err_count;

   int checks = 0;
   int passed = 0;

   // responder storage and reference-model storage, kept independent
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          ref_err = 0;
   bit          ready_stuck = 1'b0;

   always #5 clk = ~clk;

   mem_bus_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error), .err_count(err_count)
   );

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : (a ^ 32'hA5A5_5A5A);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
   endfunction

   // Command-level model: what the response and bus occupancy must be.
   function automatic void model_txn(input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wd, input int ready_at,
                                     input bit stuck, output int e_req,
                                     output logic [31:0] e_rd, output logic e_err);
      bit mis, late;
      mis  = (addr % 4) != 0;
      late = !stuck && (ready_at < 1 || ready_at > TIMEOUT);
      e_err = mis || late;
      if (mis)        e_req = 0;
      else if (stuck) e_req = 1;
      else if (late)  e_req = TIMEOUT;
      else            e_req = ready_at;
      e_rd = (e_err || wr) ? 32'd0 : ref_rd(addr);
      if (!e_err && wr) ref_mem[addr] = wd;
      if (e_err && ref_err < 255) ref_err = ref_err + 1;
   endfunction

   // Drives one command, plays the responder, holds the response for
   // 'hold' cycles, then consumes it. Observations only; no judgement.
   task automatic run_cmd(input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int ready_at,
                          input int hold, output int req_cyc, output int lat,
                          output bit bus_ok, output bit got_resp,
                          output logic [31:0] rd, output logic er,
                          output bit stable);
      int guard;
      bus_ok = 1'b1; got_resp = 1'b0; stable = 1'b1;
      req_cyc = 0; lat = 0; rd = '0; er = 1'b0; guard = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      for (int c = 1; c <= TIMEOUT + 4; c++) begin
         if (!ready_stuck) mem_ready = 1'b0;
         mem_rdata = $urandom;
         if (resp_valid === 1'b1) begin
            got_resp = 1'b1;
            lat = c;
            break;
         end
         if (mem_read === 1'b1 || mem_write === 1'b1) begin
            req_cyc++;
            if (mem_write !== wr || mem_read !== !wr || mem_addr !== addr ||
                (wr && mem_wdata !== wd))
               bus_ok = 1'b0;
            if (ready_stuck || req_cyc == ready_at) begin
               mem_ready = 1'b1;
               if (mem_write) bus_mem[mem_addr] = mem_wdata;
               else           mem_rdata = bus_rd(mem_addr);
            end
         end
         @(negedge clk);
      end
      if (got_resp) begin
         rd = resp_rdata;
         er = resp_error;
         resp_ready = 1'b0;
         for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_error !== er ||
                mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'd0 ||
                cmd_ready !== 1'b0)
               stable = 1'b0;
         end
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_wdata, resp_valid, resp_rdata,
           resp_error, err_count} !== '0 || cmd_ready !== 1'b1)
         $display("FAIL reset: bus=%b/%b addr=%h wdata=%h resp_valid=%b rdata=%h err=%b cnt=%0d cmd_ready=%b, required all 0 with cmd_ready=1",
                  mem_read, mem_write, mem_addr, mem_wdata, resp_valid,
                  resp_rdata, resp_error, err_count, cmd_ready);
      else passed++;
      reset = 1'b0;
      ref_err = 0;
   endtask

   task automatic test_aligned_read();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      bus_mem[32'h100] = 32'hDEADBEEF;
      ref_mem[32'h100] = 32'hDEADBEEF;
      model_txn(1'b0, 32'h100, 32'h0, 3, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h100, 32'h0, 3, 0, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rq !== e_req || lt !== 4 || !ok)
         $display("FAIL read_bus: req_cycles=%0d latency=%0d bus_ok=%0b, required %0d/4/1", rq, lt, ok, e_req);
      else passed++;
      checks++;
      if (!gr || rd !== e_rd || er !== e_err || !st)
         $display("FAIL read_resp: got=%0b rdata=%h err=%b stable=%0b, required 1/%h/%b/1", gr, rd, er, st, e_rd, e_err);
      else passed++;
   endtask

   task automatic test_write_backpressure();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      model_txn(1'b1, 32'h200, 32'h12345678, 1, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b1, 32'h200, 32'h12345678, 1, 4, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rq !== e_req || !ok)
         $display("FAIL write_bus: req_cycles=%0d bus_ok=%0b, required %0d/1", rq, ok, e_req);
      else passed++;
      checks++;
      if (!gr || rd !== e_rd || er !== e_err || !st)
         $display("FAIL write_backpressure: got=%0b rdata=%h err=%b stable=%0b, required 1/%h/%b/1", gr, rd, er, st, e_rd, e_err);
      else passed++;
      model_txn(1'b0, 32'h200, 32'h0, 2, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h200, 32'h0, 2, 0, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rd !== e_rd || er !== e_err)
         $display("FAIL write_readback: rdata=%h err=%b, required %h/%b", rd, er, e_rd, e_err);
      else passed++;
   endtask

   task automatic test_timeout_and_stale();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      model_txn(1'b0, 32'h300, 32'h0, 0, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h300, 32'h0, 0, 0, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rq !== e_req || lt !== TIMEOUT + 1 || !ok)
         $display("FAIL timeout_bus: req_cycles=%0d latency=%0d bus_ok=%0b, required %0d/%0d/1", rq, lt, ok, e_req, TIMEOUT + 1);
      else passed++;
      checks++;
      if (!gr || er !== e_err || rd !== e_rd || err_count !== 8'(ref_err))
         $display("FAIL timeout_resp: got=%0b err=%b rdata=%h err_count=%0d, required 1/%b/%h/%0d", gr, er, rd, err_count, e_err, e_rd, ref_err);
      else passed++;
      // ready on the final timeout edge still counts as success
      model_txn(1'b0, 32'h304, 32'h0, TIMEOUT, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h304, 32'h0, TIMEOUT, 0, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rq !== e_req || er !== e_err || rd !== e_rd)
         $display("FAIL ready_on_timeout_edge: req_cycles=%0d err=%b rdata=%h, required %0d/%b/%h", rq, er, rd, e_req, e_err, e_rd);
      else passed++;
      // ready held high across the previous response and idle
      @(negedge clk);
      ready_stuck = 1'b1;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL stale_ready_idle: cmd_ready=%b resp_valid=%b, required 1/0", cmd_ready, resp_valid);
      else passed++;
      model_txn(1'b0, 32'h308, 32'h0, 5, 1'b1, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h308, 32'h0, 5, 0, rq, lt, ok, gr, rd, er, st);
      ready_stuck = 1'b0;
      mem_ready = 1'b0;
      checks++;
      if (rq !== e_req || lt !== 2 || er !== e_err || rd !== e_rd)
         $display("FAIL stale_ready_cmd: req_cycles=%0d latency=%0d err=%b rdata=%h, required %0d/2/%b/%h", rq, lt, er, rd, e_req, e_err, e_rd);
      else passed++;
   endtask

   task automatic test_misaligned();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      int bad;
      model_txn(1'b0, 32'h102, 32'h0, 1, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h102, 32'h0, 1, 0, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (rq !== e_req || lt !== 1 || er !== e_err || rd !== e_rd || !st)
         $display("FAIL misaligned: req_cycles=%0d latency=%0d err=%b rdata=%h stable=%0b, required %0d/1/%b/%h/1", rq, lt, er, rd, st, e_req, e_err, e_rd);
      else passed++;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         bit w;
         a = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
         w = 1'($urandom);
         model_txn(w, a, $urandom, 1, 1'b0, e_req, e_rd, e_err);
         run_cmd(w, a, $urandom, 1, 0, rq, lt, ok, gr, rd, er, st);
         if (rq != 0 || er !== 1'b1 || !gr) bad++;
      end
      checks++;
      if (bad != 0 || err_count !== 8'(ref_err) || ref_err != 255)
         $display("FAIL err_saturate: err_count=%0d bad_responses=%0d, required %0d/0", err_count, bad, ref_err);
      else passed++;
   endtask

   task automatic test_random();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, wd;
         bit w;
         int ra, sel, hold;
         w   = 1'($urandom);
         a   = {$urandom_range(0, 15), 2'b00};
         if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
         wd  = $urandom;
         sel = $urandom_range(0, 9);
         ra  = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : (sel == 2) ? TIMEOUT + 1
                                : $urandom_range(1, 5);
         hold = $urandom_range(0, 3);
         model_txn(w, a, wd, ra, 1'b0, e_req, e_rd, e_err);
         run_cmd(w, a, wd, ra, hold, rq, lt, ok, gr, rd, er, st);
         checks++;
         if (!gr || rq !== e_req || lt !== e_req + 1 || rd !== e_rd ||
             er !== e_err || !ok || !st || err_count !== 8'(ref_err))
            $display("FAIL random[%0d]: w=%0b a=%h got=%0b req=%0d lat=%0d rdata=%h err=%b bus_ok=%0b stable=%0b cnt=%0d, required 1/%0d/%0d/%h/%b/1/1/%0d",
                     i, w, a, gr, rq, lt, rd, er, ok, st, err_count, e_req, e_req + 1, e_rd, e_err, ref_err);
         else passed++;
      end
   endtask

   task automatic test_reset_during_req();
      int rq, lt; bit ok, gr, st; logic [31:0] rd; logic er;
      int e_req; logic [31:0] e_rd; logic e_err;
      int guard;
      guard = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (mem_read !== 1'b1)
         $display("FAIL rst_req_start: mem_read=%b, required 1", mem_read);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ref_err = 0;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0 ||
          cmd_ready !== 1'b1 || err_count !== 8'd0)
         $display("FAIL rst_during_req: rd=%b wr=%b resp_valid=%b cmd_ready=%b cnt=%0d, required 0/0/0/1/0",
                  mem_read, mem_write, resp_valid, cmd_ready, err_count);
      else passed++;
      model_txn(1'b0, 32'h44, 32'h0, 2, 1'b0, e_req, e_rd, e_err);
      run_cmd(1'b0, 32'h44, 32'h0, 2, 1, rq, lt, ok, gr, rd, er, st);
      checks++;
      if (!gr || rq !== e_req || rd !== e_rd || er !== e_err || !ok || !st)
         $display("FAIL rst_after_cmd: got=%0b req=%0d rdata=%h err=%b, required 1/%0d/%h/%b", gr, rq, rd, er, e_req, e_rd, e_err);
      else passed++;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; mem_rdata = '0; mem_ready = 1'b0; resp_ready = 1'b0;
      test_reset();
      test_aligned_read();
      test_write_backpressure();
      test_timeout_and_stale();
      test_misaligned();
      test_random();
      test_reset_during_req();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_initiator.md
# mem_bus_initiator

Bus-master front end for the single-outstanding memory handshake (`mem_read` / `mem_write` / `mem_addr` / `mem_wdata` → `mem_rdata` / `mem_ready`) served by the processor core's memory interface block. It accepts commands on a valid/ready port and drives exactly one bus transaction at a time. It waits for `mem_ready`, with timeout protection, and returns read data or an error on a valid/ready response port. It sits between the test/DMA command source and the core's memory port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, max cycles in REQ without `mem_ready` before abort (≥2)
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  byte address; must be word aligned
- `cmd_wdata`  in  DATA_W  write data
- `mem_read`  out  1  bus read request
- `mem_write`  out  1  bus write request
- `mem_addr`  out  ADDR_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_rdata`  in  DATA_W  bus read data; valid when `mem_ready` is high
- `mem_ready`  in  1  responder completion, registered on the responder side
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  response consumed
- `resp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `resp_error`  out  1  timeout or misaligned command
- `err_count`  out  8  saturating count of errored commands

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - REQ: bus request held.
  - RESP: `resp_valid`=1.
- Reset values: state IDLE. Every output is 0, except `cmd_ready`=1 once in IDLE (it is combinational from state). `err_count`=0.
- IDLE, on `cmd_valid`:
  - Latch `cmd_write`, `cmd_addr`, and `cmd_wdata` (writes only).
  - If `cmd_addr[1:0]`≠0, go to RESP with `resp_error`=1 and `resp_rdata`=0. No bus activity.
  - Otherwise go to REQ. Clear the timeout counter.
- REQ:
  - Drive `mem_read`=~write and `mem_write`=write, with `mem_addr` and `mem_wdata` from the latches. All four are held stable for the whole state.
  - `mem_read` and `mem_write` are never high together.
  - `mem_ready` high at an edge: latch `mem_rdata` (reads) or 0 (writes), set `resp_error`=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without `mem_ready`, go to RESP with `resp_error`=1 and `resp_rdata`=0.
  - `mem_ready` on the timeout edge wins over the timeout.
- RESP:
  - Bus outputs are 0; `mem_addr` and `mem_wdata` are 0 outside REQ.
  - Hold `resp_valid`, `resp_rdata` and `resp_error` until `resp_valid`&&`resp_ready`, then go to IDLE.
- `mem_ready` is ignored outside REQ, so a stale or held ready from the previous transaction has no effect.
- `err_count` increments on entry to RESP with `resp_error`=1 and saturates at 255.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - An in-flight request is dropped with no response; bus outputs are 0 from the next cycle.
  - `err_count` clears.

## Timing
- Handshake at edge N (IDLE): `mem_read`/`mem_write` high from cycle N+1.
- `mem_ready` sampled high at edge M: request low and `resp_valid` high from cycle M+1. Minimum command-to-response latency is 2 cycles when ready arrives on the first REQ edge.
- Request deasserts for at least 2 cycles between transactions (RESP plus IDLE). Back-to-back commands: the next command is accepted no earlier than the cycle after the response handshake.
- Misaligned command: `resp_valid` high the cycle after acceptance.
- Timeout: request high for exactly TIMEOUT cycles, then `resp_valid` with error the next cycle.
- Throughput: one transaction in flight at most; `cmd_ready`=0 outside IDLE.

## Test plan
- **Reset:** assert `reset` 2 cycles → all outputs 0, `cmd_ready`=1, `err_count`=0.
- **Aligned read:** read addr 0x100, responder asserts `mem_ready` 3 cycles after `mem_read` rises with `mem_rdata`=0xDEADBEEF → `mem_read` high for exactly 3 cycles with addr 0x100; `resp_valid` next cycle with `resp_rdata`=0xDEADBEEF and `resp_error`=0.
- **Write with backpressure:** write 0x200/0x12345678, ready after 1 cycle, `resp_ready` held low 4 cycles → `mem_write`=1 and `mem_read`=0 throughout REQ; response held stable 4 cycles with rdata 0 and error 0.
- **Timeout and stale ready:**
  - TIMEOUT=16, responder silent → `mem_read` high exactly 16 cycles, `resp_error`=1, `err_count`=1.
  - A subsequent command with `mem_ready` stuck high from before acceptance completes on the first REQ edge.
- **Misaligned command:** addr 0x102 → no bus request; error response the next cycle. 300 misaligned commands → `err_count`=255.
- **Reset during REQ:** assert `reset` on the 2nd REQ cycle → bus low and no `resp_valid` the next cycle; the following command runs normally.
